// File: rtl/dcache_pkg.sv
// Shared sizes and FSM state type for the D-cache data-array controller and its refill buffer.
package dcache_pkg;

  localparam int SET_BITS_DEF  = 5;
  localparam int LINE_BITS_DEF = 256;
  localparam int WORD_BITS     = 32;
  localparam int BEAT_BITS     = 64;
  localparam int NUM_BEATS     = 4;
  localparam int BEAT_CNT_BITS = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/dcache_fill_buf.sv
// Refill beat counter and line assembly buffer; beat k lands in bits [64k+63:64k].
module dcache_fill_buf
  import dcache_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat_en,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic                 last_beat,
  output logic [LINE_BITS-1:0] line_data
);

  logic [BEAT_CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (beat_en) begin
      if (cnt_q == BEAT_CNT_BITS'(NUM_BEATS - 1)) cnt_d = '0;
      else                                        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_beat = (cnt_q == BEAT_CNT_BITS'(NUM_BEATS - 1));

  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
    logic [BEAT_BITS-1:0] beat_q, beat_d;

    always_comb begin
      beat_d = beat_q;
      if (beat_en && (cnt_q == BEAT_CNT_BITS'(gi))) beat_d = beat_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_q <= '0;
      else        beat_q <= beat_d;
    end

    assign line_data[gi*BEAT_BITS +: BEAT_BITS] = beat_q;
  end

endmodule

// File: rtl/dcache_data_ctrl.sv
// D-cache data-array controller: CPU word loads/stores and 4-beat line refills share one line-wide SRAM.
// Define DCACHE_DATA_RESP_REG_EN to register the selected load word (response latency 2 instead of 1).
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter int SET_BITS  = SET_BITS_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SET_BITS-1:0]    req_set,
  input  logic [2:0]             req_offset,
  input  logic [WORD_BITS-1:0]   req_wdata,
  input  logic [3:0]             req_wmask,
  output logic                   resp_valid,
  output logic [WORD_BITS-1:0]   resp_rdata,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [SET_BITS-1:0]    fill_set,
  input  logic [BEAT_BITS-1:0]   fill_data,
  output logic                   sram_csb,
  output logic                   sram_web,
  output logic [LINE_BITS/8-1:0] sram_wmask,
  output logic [SET_BITS-1:0]    sram_addr,
  output logic [LINE_BITS-1:0]   sram_din,
  input  logic [LINE_BITS-1:0]   sram_dout
);

  localparam int NUM_WORDS = LINE_BITS / WORD_BITS;
  localparam int MASK_BITS = LINE_BITS / 8;

  fill_state_e          state_q, state_d;
  logic [SET_BITS-1:0]  fill_set_q, fill_set_d;
  logic                 fill_ready_q, fill_ready_d;
  logic                 fill_fire;
  logic                 req_fire;
  logic                 last_beat;
  logic [LINE_BITS-1:0] fill_line;

  assign fill_ready = fill_ready_q;
  assign fill_fire  = fill_valid & fill_ready_q;

  dcache_fill_buf #(
    .LINE_BITS (LINE_BITS)
  ) u_fill_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_en   (fill_fire),
    .beat_data (fill_data),
    .last_beat (last_beat),
    .line_data (fill_line)
  );

  always_comb begin
    state_d    = state_q;
    fill_set_d = fill_set_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_fire) begin
          state_d    = ST_FILL;
          fill_set_d = fill_set;
        end
      end
      ST_FILL:  if (fill_fire && last_beat) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    fill_ready_d = (state_d != ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fill_set_q   <= '0;
      fill_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      fill_set_q   <= fill_set_d;
      fill_ready_q <= fill_ready_d;
    end
  end

  // Only the set being refilled is stalled; other sets hit under the fill.
  always_comb begin
    req_ready = 1'b1;
    if (state_q == ST_WRITE)                              req_ready = 1'b0;
    else if (state_q == ST_FILL && req_set == fill_set_q) req_ready = 1'b0;
  end

  // Reset also masks acceptance so a request held during reset never reaches the SRAM.
  assign req_fire = req_valid & req_ready & rst_n;

  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (state_q == ST_WRITE) begin
      sram_csb   = 1'b0;
      sram_web   = 1'b0;
      sram_wmask = '1;
      sram_addr  = fill_set_q;
      sram_din   = fill_line;
    end else if (req_fire) begin
      sram_csb  = 1'b0;
      sram_addr = req_set;
      if (req_we) begin
        sram_web   = 1'b0;
        sram_din   = {NUM_WORDS{req_wdata}};
        sram_wmask = MASK_BITS'(req_wmask) << {req_offset, 2'b00};
      end
    end
  end

  logic                 load_q, load_d;
  logic [2:0]           off_q, off_d;
  logic [WORD_BITS-1:0] dout_word [NUM_WORDS];
  logic [WORD_BITS-1:0] word_sel;

  always_comb begin
    load_d = req_fire & ~req_we;
    off_d  = load_d ? req_offset : off_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      off_q  <= '0;
    end else begin
      load_q <= load_d;
      off_q  <= off_d;
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    assign dout_word[gi] = sram_dout[gi*WORD_BITS +: WORD_BITS];
  end

  assign word_sel = dout_word[off_q];

`ifdef DCACHE_DATA_RESP_REG_EN
  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_BITS-1:0] resp_rdata_q, resp_rdata_d;

  always_comb begin
    resp_valid_d = load_q;
    resp_rdata_d = load_q ? word_sel : resp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
`else
  assign resp_valid = load_q;
  assign resp_rdata = load_q ? word_sel : '0;
`endif

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Self-checking bench for dcache_data_ctrl: vector table, refill/stall/reset sequences, load-response scoreboard.
`timescale 1ns/1ps
module tb_dcache_data_ctrl;

  localparam int SB = 5;
  localparam int LB = 256;
`ifdef DCACHE_DATA_RESP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [SB-1:0] req_set;
  logic [2:0]    req_offset;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wmask;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          fill_valid, fill_ready;
  logic [SB-1:0] fill_set;
  logic [63:0]   fill_data;
  logic          sram_csb, sram_web;
  logic [31:0]   sram_wmask;
  logic [SB-1:0] sram_addr;
  logic [LB-1:0] sram_din;
  logic [LB-1:0] sram_dout = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dcache_data_ctrl #(.SET_BITS(SB), .LINE_BITS(LB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_set    (req_set),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_set   (fill_set),
    .fill_data  (fill_data),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 32 x 256 SRAM with byte write mask and registered read.
  logic [LB-1:0] mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 32; b++)
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int            fill_wr_cnt = 0;
  logic [SB-1:0] last_fill_addr = '0;
  logic [LB-1:0] last_fill_din = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk256(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor and SRAM write observer, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("no_sram_op_in_reset", sram_csb, 1'b1);
      end else begin
        if (resp_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_spurious: got resp_valid=1 rdata=%h expected no response (cycle %0d)", resp_rdata, cyc);
          end else begin
            e = sbq.pop_front();
            chk32("resp_rdata", resp_rdata, e.data);
            chk32("resp_cycle", 32'(cyc), 32'(e.due));
          end
        end
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          checks++;
          failures++;
          $display("FAIL resp_missing: got no response expected data %h due cycle %0d (cycle %0d)", sbq[0].data, sbq[0].due, cyc);
          void'(sbq.pop_front());
        end
        if (!sram_csb && !sram_web && sram_wmask == 32'hFFFF_FFFF) begin
          fill_wr_cnt++;
          last_fill_addr = sram_addr;
          last_fill_din  = sram_din;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish within 200000 ns");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] pat64(input logic [3:0] n);
    return {16{n}};
  endfunction

  function automatic logic [31:0] pat32(input logic [3:0] n);
    return {8{n}};
  endfunction

  // One clock of stimulus on both interfaces; called and returns at posedge+1.
  task automatic step(input logic rv, input logic we, input logic [4:0] set, input logic [2:0] off,
                      input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp_rd,
                      input logic fv, input logic [4:0] fs, input logic [63:0] fd,
                      output logic racc, output logic facc);
    req_valid = rv; req_we = we; req_set = set; req_offset = off; req_wdata = wd; req_wmask = wm;
    fill_valid = fv; fill_set = fs; fill_data = fd;
    @(negedge clk);
    racc = rv && req_ready;
    facc = fv && fill_ready;
    if (racc && !we) sbq.push_back('{exp_rd, cyc + LAT});
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; fill_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic ra, fa;
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra, fa);
  endtask

  task automatic chk_reset_vals();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_fill_ready", fill_ready, 1'b1);
    chk1("rst_sram_csb", sram_csb, 1'b1);
    chk1("rst_sram_web", sram_web, 1'b1);
    chk32("rst_sram_wmask", sram_wmask, 32'h0);
    chk32("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk256("rst_sram_din", sram_din, '0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  set;
    logic [2:0]  off;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] exp_wmask;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic ra, fa;
    int   wr_before;
    logic [7:0] din_byte;

    vecs[0] = '{1'b1, 5'd3, 3'd5, 32'hDEAD_BEEF, 4'hF, 32'h00F0_0000, 32'h0};
    vecs[1] = '{1'b0, 5'd3, 3'd5, 32'h0,         4'h0, 32'h0,        32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd9, 3'd2, 32'h1122_3344, 4'h4, 32'h0000_0400, 32'h0};
    vecs[3] = '{1'b0, 5'd9, 3'd2, 32'h0,         4'h0, 32'h0,        32'h0022_0000};
    vecs[4] = '{1'b1, 5'd3, 3'd0, 32'hCAFE_F00D, 4'h3, 32'h0000_0003, 32'h0};
    vecs[5] = '{1'b0, 5'd3, 3'd0, 32'h0,         4'h0, 32'h0,        32'h0000_F00D};
    vecs[6] = '{1'b0, 5'd3, 3'd5, 32'h0,         4'h0, 32'h0,        32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 5'd3, 3'd7, 32'hA5A5_A5A5, 4'h8, 32'h8000_0000, 32'h0};
    vecs[8] = '{1'b0, 5'd3, 3'd7, 32'h0,         4'h0, 32'h0,        32'hA500_0000};

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_set = 0; req_offset = 0; req_wdata = 0; req_wmask = 0;
    fill_valid = 0; fill_set = 0; fill_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Table: single-cycle stores and loads, SRAM port fields checked in the accept cycle.
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_set = vecs[i].set; req_offset = vecs[i].off;
      req_wdata = vecs[i].wd; req_wmask = vecs[i].wm;
      @(negedge clk);
      chk1("vec_req_ready", req_ready, 1'b1);
      chk1("vec_sram_csb", sram_csb, 1'b0);
      chk1("vec_sram_web", sram_web, ~vecs[i].we);
      chk32("vec_sram_addr", 32'(sram_addr), 32'(vecs[i].set));
      chk32("vec_sram_wmask", sram_wmask, vecs[i].exp_wmask);
      if (vecs[i].we) chk256("vec_sram_din", sram_din, {8{vecs[i].wd}});
      if (i == 2) begin
        din_byte = sram_din[87:80];
        chk32("vec_din_byte10", 32'(din_byte), 32'h22);
      end
      if (req_ready && !vecs[i].we) sbq.push_back('{vecs[i].exp_rd, cyc + LAT});
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b0;
    end
    idle(3);

    // Back-to-back load/store/load to one set.
    step(1, 0, 3, 5, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, ra, fa);
    chk1("b2b_load1_acc", ra, 1'b1);
    step(1, 1, 3, 5, 32'h1234_5678, 4'hF, 0, 0, 0, 0, ra, fa);
    chk1("b2b_store_acc", ra, 1'b1);
    step(1, 0, 3, 5, 0, 0, 32'h1234_5678, 0, 0, 0, ra, fa);
    chk1("b2b_load2_acc", ra, 1'b1);
    idle(3);

    // Refill of set 7 with hit-under-fill to set 2 and stall of set 7 until IDLE.
    wr_before = fill_wr_cnt;
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, pat64(4'h0), ra, fa);
    chk1("fill_b0_acc", fa, 1'b1);
    step(1, 0, 2, 0, 0, 0, 32'h0, 1, 5'd5, pat64(4'h1), ra, fa);
    chk1("fill_b1_acc", fa, 1'b1);
    chk1("hit_under_fill_acc", ra, 1'b1);
    step(1, 0, 7, 0, 0, 0, 32'h0, 1, 5'd5, pat64(4'h2), ra, fa);
    chk1("fill_b2_acc", fa, 1'b1);
    chk1("same_set_stall_b2", ra, 1'b0);
    step(1, 0, 7, 0, 0, 0, 32'h0, 1, 5'd5, pat64(4'h3), ra, fa);
    chk1("fill_b3_acc", fa, 1'b1);
    chk1("same_set_stall_b3", ra, 1'b0);
    step(1, 0, 7, 0, 0, 0, 32'h0, 1, 5'd5, pat64(4'h9), ra, fa);
    chk1("write_req_stall", ra, 1'b0);
    chk1("write_fill_stall", fa, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 7, 3'(j), 0, 0, pat32(4'(j / 2)), 0, 0, 0, ra, fa);
      chk1("fill_load_acc", ra, 1'b1);
    end
    chk32("fill_write_count", 32'(fill_wr_cnt - wr_before), 32'd1);
    chk32("fill_write_addr", 32'(last_fill_addr), 32'd7);
    chk256("fill_write_din", last_fill_din, {pat64(4'h3), pat64(4'h2), pat64(4'h1), pat64(4'h0)});
    idle(3);

    // Partial fill to set 12 killed by reset, then a fresh fill to set 20 with a load in beat 0.
    wr_before = fill_wr_cnt;
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, pat64(4'hE), ra, fa);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, pat64(4'hD), ra, fa);
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_set = 12; req_offset = 0; req_wdata = 32'hFFFF_FFFF; req_wmask = 4'hF;
    @(negedge clk);
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 20, 3, 0, 0, 32'h0, 1, 20, pat64(4'h4), ra, fa);
    chk1("idle_req_with_b0_acc", ra, 1'b1);
    chk1("idle_b0_with_req_acc", fa, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, pat64(4'h5), ra, fa);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, pat64(4'h6), ra, fa);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, pat64(4'h7), ra, fa);
    idle(2);
    chk32("refill_write_count", 32'(fill_wr_cnt - wr_before), 32'd1);
    chk32("refill_write_addr", 32'(last_fill_addr), 32'd20);
    chk256("refill_write_din", last_fill_din, {pat64(4'h7), pat64(4'h6), pat64(4'h5), pat64(4'h4)});
    step(1, 0, 20, 0, 0, 0, 32'h4444_4444, 0, 0, 0, ra, fa);
    step(1, 0, 20, 7, 0, 0, 32'h7777_7777, 0, 0, 0, ra, fa);
    step(1, 0, 12, 0, 0, 0, 32'h0, 0, 0, 0, ra, fa);
    idle(3);

    // Reset asserted while the completed fill is in WRITE: the line must not be written.
    wr_before = fill_wr_cnt;
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 25, pat64(4'(k + 1)), ra, fa);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk32("write_reset_count", 32'(fill_wr_cnt - wr_before), 32'd0);
    step(1, 0, 25, 2, 0, 0, 32'h0, 0, 0, 0, ra, fa);
    idle(4);
    chk32("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_data_ctrl.md
DCACHE_DATA_CTRL -- requirements
Module: dcache_data_ctrl

Interface
REQ-001 SHALL have parameter SET_BITS, default 5: set-index width, matching the 32-set data SRAM.
REQ-002 SHALL have parameter LINE_BITS, default 256: line width; word 32 bits, fill beat 64 bits, 4 beats per line.
REQ-003 SHALL have ports clk (in, 1, clock), then rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have req_valid/req_ready (in/out, 1): CPU access handshake.
REQ-005 SHALL have req_we (in, 1, store), req_set (in, SET_BITS), req_offset (in, 3, word in line), req_wdata (in, 32), req_wmask (in, 4, byte enables).
REQ-006 SHALL have resp_valid (out, 1) and resp_rdata (out, 32): load response.
REQ-007 SHALL have fill_valid/fill_ready (in/out, 1), fill_set (in, SET_BITS) and fill_data (in, 64): refill beats from memory.
REQ-008 SHALL have SRAM ports sram_csb (out, 1, active-low), sram_web (out, 1, active-low), sram_wmask (out, 32), sram_addr (out, SET_BITS), sram_din (out, LINE_BITS) and sram_dout (in, LINE_BITS).

Function
REQ-009 SHALL drive SRAM fields combinationally in the cycle a request is accepted; the SRAM samples them at the next edge.
REQ-010 SHALL, on an accepted store, drive csb=0, web=0, sram_din = req_wdata replicated 8x and sram_wmask = req_wmask shifted left by 4*req_offset.
REQ-011 SHALL, on an accepted load, drive csb=0, web=1, wmask=0, register req_offset, and return resp_valid with word req_offset of sram_dout exactly 1 cycle later.
REQ-012 SHALL deassert resp_valid in every cycle that follows no accepted load; stores produce no response.
REQ-013 SHALL implement FSM IDLE -> FILL on the first fill beat (latch fill_set, beat counter to 1); FILL -> WRITE when beat 3 is accepted; WRITE -> IDLE after 1 cycle.
REQ-014 SHALL store beat k in buffer bits [64k+63:64k], k counting 0..3 and wrapping to 0 on entering WRITE.
REQ-015 SHALL, in WRITE, drive csb=0, web=0, wmask=all ones, addr=latched fill set and din=buffer, and hold req_ready=0 and fill_ready=0.
REQ-016 SHALL hold fill_ready=1 in IDLE and FILL, and ignore fill_set on beats 1..3.
REQ-017 SHALL, in FILL, hold req_ready=0 only when req_set equals the latched fill set; other sets proceed (hit-under-fill).
REQ-018 SHALL, when req and fill beat 0 arrive together in IDLE, accept both in that cycle.
REQ-019 SHALL, when a load accepted at cycle N is followed by a store to the same set at N+1, return data from before the store at N+1.
REQ-020 SHALL drive sram_csb=1 in every cycle with no SRAM operation.

Reset
REQ-021 SHALL, while rst_n=0: FSM=IDLE, beat counter=0, buffer=0, resp_valid=0, resp_rdata=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, req_ready=1, fill_ready=1.
REQ-022 SHALL discard a partial fill on reset, and on reset during WRITE drive no SRAM write.

Configuration
REQ-023 SHALL, with DCACHE_DATA_RESP_REG_EN defined, register the selected word: resp_valid/resp_rdata 2 cycles after load acceptance, from flops.
REQ-024 SHALL, without DCACHE_DATA_RESP_REG_EN, take response latency 1 with resp_rdata combinational from sram_dout.

Structure
REQ-025 SHALL take SET_BITS/LINE_BITS defaults, beat count, beat width and the FSM state enum typedef from shared package dcache_pkg.
REQ-026 SHALL put the beat counter and 256-bit assembly buffer in sub-module dcache_fill_buf; the FSM and SRAM muxing stay in dcache_data_ctrl.

Verification
REQ-027 SHALL cover: store set 3, offset 5, wdata 0xDEADBEEF, wmask 0xF, then load set 3 offset 5 -> resp_valid at +1 (+2 with macro), rdata 0xDEADBEEF.
REQ-028 SHALL cover: store wmask 0x4 at offset 2 -> sram_wmask 0x00000400, sram_din bits [87:80] = wdata [23:16].
REQ-029 SHALL cover: 4 fill beats 0x0..0,...,0x3..3 to set 7 -> one WRITE with wmask 0xFFFFFFFF, addr 7; loads of offsets 0..7 return the beat halves in order.
REQ-030 SHALL cover: during FILL of set 7, load to set 7 -> req_ready=0 until IDLE; load to set 2 -> accepted immediately.
REQ-031 SHALL cover: rst_n low after 2 beats, then a fresh 4-beat fill -> only the fresh data is written, no SRAM write during reset.
REQ-032 SHALL cover: back-to-back load/store/load to one set -> 1st load returns old data, 2nd load returns the stored data.
